// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: control bundle layout, ALU operation
// codes, opcode constants and the bubble (NOP) control value.
package id_ex_stage_pkg;

    localparam int unsigned CTRL_FLAGS_W = 8;
    localparam int unsigned ALUOP_W      = 5;
    localparam int unsigned CTRL_W       = CTRL_FLAGS_W + ALUOP_W;

    typedef struct packed {
        logic                reg_write;
        logic                reg_dst;
        logic                alu_src;
        logic                branch;
        logic                mem_write;
        logic                mem_read;
        logic                mem_to_reg;
        logic                zero_ext;
        logic [ALUOP_W-1:0]  alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 5'b00000;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDI  = 5'b00001;
    localparam logic [ALUOP_W-1:0] ALUOP_MUL   = 5'b00011;
    localparam logic [ALUOP_W-1:0] ALUOP_ANDI  = 5'b10100;
    localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 5'b10101;
    localparam logic [ALUOP_W-1:0] ALUOP_XORI  = 5'b11001;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTI  = 5'b11101;

    localparam int unsigned OPCODE_W = 6;
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPCODE_W-1:0] OP_MUL   = 6'h1C;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detector: flags an ID instruction that reads the register a
// load currently in EX is about to write.
module hazard_detect_unit #(
    parameter int unsigned RW = 5
) (
    input  logic          ex_valid,
    input  logic          ex_mem_read,
    input  logic [RW-1:0] ex_rt,
    input  logic          id_valid,
    input  logic          id_alu_src,
    input  logic          id_mem_write,
    input  logic          id_branch,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          flush,
    output logic          hazard_stall_c
);

    logic use_rt_c;
    logic rs_hit_c;
    logic rt_hit_c;

    // Rt is a true source for R-type ALU ops, stores (data) and branches (compare).
    always_comb begin
        use_rt_c       = !id_alu_src | id_mem_write | id_branch;
        rs_hit_c       = (ex_rt == id_rs);
        rt_hit_c       = use_rt_c & (ex_rt == id_rt);
        hazard_stall_c = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid & !flush
                         & (rs_hit_c | rt_hit_c);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush, external
// hold and a saturating bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned RW    = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Hold,
    input  logic             Flush,
    input  logic             id_valid,
    input  logic             id_RegWrite,
    input  logic             id_RegDst,
    input  logic             id_ALUSrc,
    input  logic             id_Branch,
    input  logic             id_MemWrite,
    input  logic             id_MemRead,
    input  logic             id_MemToReg,
    input  logic             id_zeroExt,
    input  logic [4:0]       id_ALUOp,
    input  logic [DW-1:0]    id_PCPlus4,
    input  logic [DW-1:0]    id_ReadData1,
    input  logic [DW-1:0]    id_ReadData2,
    input  logic [DW-1:0]    id_Imm,
    input  logic [RW-1:0]    id_Rs,
    input  logic [RW-1:0]    id_Rt,
    input  logic [RW-1:0]    id_Rd,
    output logic             ex_valid,
    output logic             ex_RegWrite,
    output logic             ex_RegDst,
    output logic             ex_ALUSrc,
    output logic             ex_Branch,
    output logic             ex_MemWrite,
    output logic             ex_MemRead,
    output logic             ex_MemToReg,
    output logic             ex_zeroExt,
    output logic [4:0]       ex_ALUOp,
    output logic [DW-1:0]    ex_PCPlus4,
    output logic [DW-1:0]    ex_ReadData1,
    output logic [DW-1:0]    ex_ReadData2,
    output logic [DW-1:0]    ex_Imm,
    output logic [RW-1:0]    ex_Rs,
    output logic [RW-1:0]    ex_Rt,
    output logic [RW-1:0]    ex_Rd,
    output logic             HazardStall,
    output logic [CNT_W-1:0] BubbleCount
);

    ctrl_t             id_ctrl;
    ctrl_t             ctrl_d,  ctrl_q;
    logic              valid_d, valid_q;
    logic [DW-1:0]     pc_d,    pc_q;
    logic [DW-1:0]     rd1_d,   rd1_q;
    logic [DW-1:0]     rd2_d,   rd2_q;
    logic [DW-1:0]     imm_d,   imm_q;
    logic [RW-1:0]     rs_d,    rs_q;
    logic [RW-1:0]     rt_d,    rt_q;
    logic [RW-1:0]     rd_d,    rd_q;
    logic [CNT_W-1:0]  cnt_d,   cnt_q;
    logic              hazard_stall_c;

    assign id_ctrl = '{reg_write:  id_RegWrite,
                       reg_dst:    id_RegDst,
                       alu_src:    id_ALUSrc,
                       branch:     id_Branch,
                       mem_write:  id_MemWrite,
                       mem_read:   id_MemRead,
                       mem_to_reg: id_MemToReg,
                       zero_ext:   id_zeroExt,
                       alu_op:     id_ALUOp};

    hazard_detect_unit #(
        .RW (RW)
    ) u_hazard (
        .ex_valid       (valid_q),
        .ex_mem_read    (ctrl_q.mem_read),
        .ex_rt          (rt_q),
        .id_valid       (id_valid),
        .id_alu_src     (id_ALUSrc),
        .id_mem_write   (id_MemWrite),
        .id_branch      (id_Branch),
        .id_rs          (id_Rs),
        .id_rt          (id_Rt),
        .flush          (Flush),
        .hazard_stall_c (hazard_stall_c)
    );

    // Next-state: flush beats hold, hold beats a bubble; data fields only move on a load.
    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (Flush) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
        end else if (!Hold) begin
            if (hazard_stall_c) begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_NOP;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                valid_d = id_valid;
                ctrl_d  = id_valid ? id_ctrl : CTRL_NOP;
                pc_d    = id_PCPlus4;
                rd1_d   = id_ReadData1;
                rd2_d   = id_ReadData2;
                imm_d   = id_Imm;
                rs_d    = id_Rs;
                rt_d    = id_Rt;
                rd_d    = id_Rd;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ctrl_q  <= CTRL_NOP;
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_RegWrite  = ctrl_q.reg_write;
    assign ex_RegDst    = ctrl_q.reg_dst;
    assign ex_ALUSrc    = ctrl_q.alu_src;
    assign ex_Branch    = ctrl_q.branch;
    assign ex_MemWrite  = ctrl_q.mem_write;
    assign ex_MemRead   = ctrl_q.mem_read;
    assign ex_MemToReg  = ctrl_q.mem_to_reg;
    assign ex_zeroExt   = ctrl_q.zero_ext;
    assign ex_ALUOp     = ctrl_q.alu_op;
    assign ex_PCPlus4   = pc_q;
    assign ex_ReadData1 = rd1_q;
    assign ex_ReadData2 = rd2_q;
    assign ex_Imm       = imm_q;
    assign ex_Rs        = rs_q;
    assign ex_Rt        = rt_q;
    assign ex_Rd        = rd_q;
    assign HazardStall  = hazard_stall_c;
    assign BubbleCount  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver predicts each cycle from a field-level
// reference model; monitor compares stall (pre-edge) and EX state (post-edge).
module tb_id_ex_stage;

    // flag bit order: [7]RegWrite [6]RegDst [5]ALUSrc [4]Branch [3]MemWrite [2]MemRead [1]MemToReg [0]zeroExt
    localparam logic [7:0] F_ADDI  = 8'b1010_0000;
    localparam logic [7:0] F_LW    = 8'b1010_0110;
    localparam logic [7:0] F_RTYPE = 8'b1100_0000;

    typedef struct {
        logic        rst, hold, flush, valid;
        logic [7:0]  flags;
        logic [4:0]  aluop;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
    } in_t;

    typedef struct {
        logic        valid;
        logic [7:0]  flags;
        logic [4:0]  aluop;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        int          bubbles;
    } st_t;

    typedef struct {
        logic stall_known;
        logic stall;
        logic data_known;
        st_t  nxt;
    } exp_t;

    logic Clk;
    logic Rst, Hold, Flush, id_valid;
    logic id_RegWrite, id_RegDst, id_ALUSrc, id_Branch, id_MemWrite, id_MemRead, id_MemToReg, id_zeroExt;
    logic [4:0]  id_ALUOp;
    logic [31:0] id_PCPlus4, id_ReadData1, id_ReadData2, id_Imm;
    logic [4:0]  id_Rs, id_Rt, id_Rd;

    logic        ex_valid, ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_Branch, ex_MemWrite, ex_MemRead, ex_MemToReg, ex_zeroExt;
    logic [4:0]  ex_ALUOp;
    logic [31:0] ex_PCPlus4, ex_ReadData1, ex_ReadData2, ex_Imm;
    logic [4:0]  ex_Rs, ex_Rt, ex_Rd;
    logic        HazardStall;
    logic [15:0] BubbleCount;

    logic        s_valid, s_RegWrite, s_RegDst, s_ALUSrc, s_Branch, s_MemWrite, s_MemRead, s_MemToReg, s_zeroExt;
    logic [4:0]  s_ALUOp;
    logic [31:0] s_PCPlus4, s_ReadData1, s_ReadData2, s_Imm;
    logic [4:0]  s_Rs, s_Rt, s_Rd;
    logic        s_HazardStall;
    logic [1:0]  s_BubbleCount;

    id_ex_stage u_dut (
        .Clk(Clk), .Rst(Rst), .Hold(Hold), .Flush(Flush), .id_valid(id_valid),
        .id_RegWrite(id_RegWrite), .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_Branch(id_Branch),
        .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead), .id_MemToReg(id_MemToReg), .id_zeroExt(id_zeroExt),
        .id_ALUOp(id_ALUOp), .id_PCPlus4(id_PCPlus4), .id_ReadData1(id_ReadData1), .id_ReadData2(id_ReadData2),
        .id_Imm(id_Imm), .id_Rs(id_Rs), .id_Rt(id_Rt), .id_Rd(id_Rd),
        .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc),
        .ex_Branch(ex_Branch), .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead), .ex_MemToReg(ex_MemToReg),
        .ex_zeroExt(ex_zeroExt), .ex_ALUOp(ex_ALUOp), .ex_PCPlus4(ex_PCPlus4), .ex_ReadData1(ex_ReadData1),
        .ex_ReadData2(ex_ReadData2), .ex_Imm(ex_Imm), .ex_Rs(ex_Rs), .ex_Rt(ex_Rt), .ex_Rd(ex_Rd),
        .HazardStall(HazardStall), .BubbleCount(BubbleCount)
    );

    // Narrow-counter instance driven identically, used for the saturation check.
    id_ex_stage #(.CNT_W(2)) u_sat (
        .Clk(Clk), .Rst(Rst), .Hold(Hold), .Flush(Flush), .id_valid(id_valid),
        .id_RegWrite(id_RegWrite), .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_Branch(id_Branch),
        .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead), .id_MemToReg(id_MemToReg), .id_zeroExt(id_zeroExt),
        .id_ALUOp(id_ALUOp), .id_PCPlus4(id_PCPlus4), .id_ReadData1(id_ReadData1), .id_ReadData2(id_ReadData2),
        .id_Imm(id_Imm), .id_Rs(id_Rs), .id_Rt(id_Rt), .id_Rd(id_Rd),
        .ex_valid(s_valid), .ex_RegWrite(s_RegWrite), .ex_RegDst(s_RegDst), .ex_ALUSrc(s_ALUSrc),
        .ex_Branch(s_Branch), .ex_MemWrite(s_MemWrite), .ex_MemRead(s_MemRead), .ex_MemToReg(s_MemToReg),
        .ex_zeroExt(s_zeroExt), .ex_ALUOp(s_ALUOp), .ex_PCPlus4(s_PCPlus4), .ex_ReadData1(s_ReadData1),
        .ex_ReadData2(s_ReadData2), .ex_Imm(s_Imm), .ex_Rs(s_Rs), .ex_Rt(s_Rt), .ex_Rd(s_Rd),
        .HazardStall(s_HazardStall), .BubbleCount(s_BubbleCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    exp_t sbq[$];
    int   n_vec   = 0;
    int   n_miss  = 0;
    int   n_push  = 0;
    int   n_done  = 0;

    st_t  ms;
    logic m_known = 1'b0;
    logic m_data  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int c, input int m);
        return (c > m) ? m : c;
    endfunction

    // A load in EX collides with an ID reader of its destination (never $0).
    function automatic logic model_stall(input st_t s, input in_t v);
        logic reads_rt;
        reads_rt = !v.flags[5] || v.flags[3] || v.flags[4];
        return s.valid && s.flags[2] && (s.rt != 5'd0) && v.valid && !v.flush
               && ((s.rt == v.rs) || (reads_rt && s.rt == v.rt));
    endfunction

    function automatic in_t idle();
        in_t v;
        v = '{rst: 1'b0, hold: 1'b0, flush: 1'b0, valid: 1'b1, flags: 8'h00, aluop: 5'd0,
              pc: 32'h0, rd1: 32'h0, rd2: 32'h0, imm: 32'h0, rs: 5'd0, rt: 5'd0, rd: 5'd0};
        return v;
    endfunction

    function automatic in_t instr(input logic [7:0] f, input logic [4:0] op,
                                  input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
        in_t v;
        v       = idle();
        v.flags = f;
        v.aluop = op;
        v.rs    = rs;
        v.rt    = rt;
        v.rd    = 5'($urandom_range(0, 31));
        v.imm   = imm;
        v.pc    = $urandom;
        v.rd1   = $urandom;
        v.rd2   = $urandom;
        return v;
    endfunction

    function automatic in_t rand_in();
        in_t v;
        v       = instr(8'($urandom), 5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
        v.flags[2] = ($urandom_range(0, 2) == 0);
        v.valid = ($urandom_range(0, 5) != 0);
        v.flush = ($urandom_range(0, 9) == 0);
        v.hold  = ($urandom_range(0, 9) == 0);
        v.rst   = ($urandom_range(0, 79) == 0);
        return v;
    endfunction

    // Drive one cycle of inputs and push the predicted stall and next EX state.
    task automatic apply(input in_t v);
        exp_t e;
        logic st;
        @(negedge Clk);
        Rst = v.rst; Hold = v.hold; Flush = v.flush; id_valid = v.valid;
        {id_RegWrite, id_RegDst, id_ALUSrc, id_Branch, id_MemWrite, id_MemRead, id_MemToReg, id_zeroExt} = v.flags;
        id_ALUOp = v.aluop; id_PCPlus4 = v.pc; id_ReadData1 = v.rd1; id_ReadData2 = v.rd2;
        id_Imm = v.imm; id_Rs = v.rs; id_Rt = v.rt; id_Rd = v.rd;
        st = model_stall(ms, v);
        e.stall_known = m_known;
        e.stall       = st;
        if (v.rst) begin
            ms = '{valid: 1'b0, flags: 8'h00, aluop: 5'd0, pc: 32'h0, rd1: 32'h0, rd2: 32'h0,
                   imm: 32'h0, rs: 5'd0, rt: 5'd0, rd: 5'd0, bubbles: 0};
            m_known = 1'b1;
            m_data  = 1'b1;
        end else if (v.flush || (!v.hold && st)) begin
            ms.valid = 1'b0;
            ms.flags = 8'h00;
            ms.aluop = 5'd0;
            m_data   = 1'b0;
            if (!v.flush) ms.bubbles++;
        end else if (!v.hold) begin
            ms.valid = v.valid;
            ms.flags = v.valid ? v.flags : 8'h00;
            ms.aluop = v.valid ? v.aluop : 5'd0;
            ms.pc = v.pc; ms.rd1 = v.rd1; ms.rd2 = v.rd2; ms.imm = v.imm;
            ms.rs = v.rs; ms.rt = v.rt; ms.rd = v.rd;
            m_data = 1'b1;
        end
        e.nxt        = ms;
        e.data_known = m_data && m_known;
        sbq.push_back(e);
        n_push++;
    endtask

    // Monitor: stall is checked before the edge, registered state after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            #3;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                if (e.stall_known) begin
                    chk("hazard_stall", 32'(HazardStall), 32'(e.stall));
                    chk("hazard_stall_cnt2", 32'(s_HazardStall), 32'(e.stall));
                end
                @(posedge Clk);
                #1;
                if (e.nxt.valid !== 1'bx) begin
                    chk("ex_valid", 32'(ex_valid), 32'(e.nxt.valid));
                    chk("ex_ctrl", 32'({ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_Branch, ex_MemWrite,
                                        ex_MemRead, ex_MemToReg, ex_zeroExt, ex_ALUOp}),
                        32'({e.nxt.flags, e.nxt.aluop}));
                    chk("bubble_count", 32'(BubbleCount), 32'(sat(e.nxt.bubbles, 65535)));
                    chk("bubble_count_cnt2", 32'(s_BubbleCount), 32'(sat(e.nxt.bubbles, 3)));
                    if (e.data_known) begin
                        chk("ex_PCPlus4", ex_PCPlus4, e.nxt.pc);
                        chk("ex_ReadData1", ex_ReadData1, e.nxt.rd1);
                        chk("ex_ReadData2", ex_ReadData2, e.nxt.rd2);
                        chk("ex_Imm", ex_Imm, e.nxt.imm);
                        chk("ex_regs", 32'({ex_Rs, ex_Rt, ex_Rd}), 32'({e.nxt.rs, e.nxt.rt, e.nxt.rd}));
                    end
                end
                n_done++;
            end
        end
    end

    initial begin
        in_t v;
        ms = '{valid: 1'bx, flags: 8'hxx, aluop: 5'bx, pc: 32'hx, rd1: 32'hx, rd2: 32'hx,
               imm: 32'hx, rs: 5'bx, rt: 5'bx, rd: 5'bx, bubbles: 0};
        v = idle(); v.rst = 1'b1;
        apply(v);
        apply(v);

        // addi, then load-use with an R-type reader
        apply(instr(F_ADDI, 5'b00001, 5'd3, 5'd4, 32'h0000_0010));
        apply(instr(F_LW, 5'b00001, 5'd1, 5'd8, 32'h4));
        v = instr(F_RTYPE, 5'b00000, 5'd2, 5'd8, 32'h0);
        apply(v);
        apply(v);

        // $0 destination and immediate-form reader never stall
        apply(instr(F_LW, 5'b00001, 5'd1, 5'd0, 32'h8));
        apply(instr(F_RTYPE, 5'b00000, 5'd0, 5'd0, 32'h0));
        apply(instr(F_LW, 5'b00001, 5'd1, 5'd5, 32'h8));
        apply(instr(F_ADDI, 5'b00001, 5'd1, 5'd5, 32'h20));

        // flush coincident with a hazard
        apply(instr(F_LW, 5'b00001, 5'd1, 5'd8, 32'hC));
        v = instr(F_RTYPE, 5'b00000, 5'd8, 5'd2, 32'h0); v.flush = 1'b1;
        apply(v);

        // hold for three cycles with changing inputs, then hold+flush
        apply(instr(F_ADDI, 5'b10101, 5'd6, 5'd7, 32'h1234));
        for (int i = 0; i < 3; i++) begin
            v = rand_in(); v.rst = 1'b0; v.flush = 1'b0; v.hold = 1'b1;
            apply(v);
        end
        v = rand_in(); v.rst = 1'b0; v.flush = 1'b1; v.hold = 1'b1;
        apply(v);

        // five load-use bubbles to saturate the narrow counter
        for (int i = 0; i < 5; i++) begin
            apply(instr(F_LW, 5'b00001, 5'd1, 5'd9, 32'h10));
            v = instr(F_RTYPE, 5'b00000, 5'd9, 5'd3, 32'h0);
            apply(v);
            apply(v);
        end

        // reset while a stall is being requested
        apply(instr(F_LW, 5'b00001, 5'd1, 5'd9, 32'h10));
        v = instr(F_RTYPE, 5'b00000, 5'd9, 5'd3, 32'h0); v.rst = 1'b1;
        apply(v);
        v.rst = 1'b0;
        apply(v);

        for (int i = 0; i < 600; i++) apply(rand_in());

        for (int k = 0; k < 50 && n_done < n_push; k++) @(posedge Clk);
        #5;
        if (n_done < n_push) begin
            n_miss++;
            $display("FAIL drain: %0d of %0d expectations checked", n_done, n_push);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
